// File: rtl/aq_div_pkg.sv
// Shared types and helpers for the pipelined unsigned divider.
package aq_div_pkg;

  // Per-operation exception flags that travel with the data.
  typedef struct packed {
    logic divz;
    logic ovf;
  } aq_div_flags_t;

  // One guard bit over the divisor holds the shifted trial remainder.
  function automatic int unsigned aq_pr_width(input int unsigned divisor_w);
    return divisor_w + 32'd1;
  endfunction

endpackage

// File: rtl/aq_div_stage.sv
// One restoring shift-subtract step of the divider, with its own valid/hold register.
module aq_div_stage
  import aq_div_pkg::*;
#(
  parameter int unsigned DIVISOR_W = 16,
  parameter int unsigned QUOT_W    = 8,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned STAGE     = 0,
  localparam int unsigned PR_W     = aq_pr_width(DIVISOR_W)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 adv,
  input  logic                 up_valid,
  input  logic [PR_W-1:0]      up_prem,
  input  logic [QUOT_W-1:0]    up_dvd,
  input  logic [DIVISOR_W-1:0] up_dvs,
  input  logic [QUOT_W-1:0]    up_q,
  input  aq_div_flags_t        up_flags,
  input  logic [TAG_W-1:0]     up_tag,
  output logic                 dn_valid,
  output logic [PR_W-1:0]      dn_prem,
  output logic [QUOT_W-1:0]    dn_dvd,
  output logic [DIVISOR_W-1:0] dn_dvs,
  output logic [QUOT_W-1:0]    dn_q,
  output aq_div_flags_t        dn_flags,
  output logic [TAG_W-1:0]     dn_tag
);

  logic [PR_W:0]       trial_s;
  logic                qbit_s;
  logic [PR_W-1:0]     prem_s;
  logic [QUOT_W-1:0]   q_s;

  // Trial subtract of the divisor from the remainder with the next dividend bit shifted in.
  always_comb begin
    trial_s = {up_prem, up_dvd[QUOT_W-1]};
    if (trial_s >= {2'b00, up_dvs}) begin
      qbit_s = 1'b1;
      prem_s = PR_W'(trial_s - {2'b00, up_dvs});
    end else begin
      qbit_s = 1'b0;
      prem_s = PR_W'(trial_s);
    end
    // The last quotient step saturates exceptional results to all-ones.
    if ((STAGE == QUOT_W - 1) && (up_flags.divz || up_flags.ovf)) begin
      q_s = {QUOT_W{1'b1}};
    end else begin
      q_s = QUOT_W'({up_q, qbit_s});
    end
  end

  // Stage register: loads on global advance, otherwise holds valid and data together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dn_valid <= 1'b0;
      dn_prem  <= {PR_W{1'b0}};
      dn_dvd   <= {QUOT_W{1'b0}};
      dn_dvs   <= {DIVISOR_W{1'b0}};
      dn_q     <= {QUOT_W{1'b0}};
      dn_flags <= '{divz: 1'b0, ovf: 1'b0};
      dn_tag   <= {TAG_W{1'b0}};
    end else if (adv) begin
      dn_valid <= up_valid;
      dn_prem  <= prem_s;
      dn_dvd   <= up_dvd << 1'b1;
      dn_dvs   <= up_dvs;
      dn_q     <= q_s;
      dn_flags <= up_flags;
      dn_tag   <= up_tag;
    end
  end

endmodule

// File: rtl/aq_div_pipe.sv
// Fully pipelined unsigned divider with valid/ready flow control and sideband tag.
// Define AQ_DIV_PIPE_REMAINDER_EN to add a final stage that also returns the remainder on REM.
module aq_div_pipe
  import aq_div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = 24,
  parameter int unsigned DIVISOR_W  = 16,
  parameter int unsigned QUOT_W     = 8,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DIVIDEND_W-1:0] DINA,
  input  logic [DIVISOR_W-1:0]  DINB,
  input  logic [TAG_W-1:0]      TAG_IN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [QUOT_W-1:0]     DOUT,
  output logic                  DIVZ,
  output logic                  OVF,
  output logic [TAG_W-1:0]      TAG_OUT,
  output logic [DIVISOR_W-1:0]  REM
);

  localparam int unsigned PR_W = aq_pr_width(DIVISOR_W);

  logic                 adv_s;
  logic                 valid_s [0:QUOT_W];
  logic [PR_W-1:0]      prem_s  [0:QUOT_W];
  logic [QUOT_W-1:0]    dvd_s   [0:QUOT_W];
  logic [DIVISOR_W-1:0] dvs_s   [0:QUOT_W];
  logic [QUOT_W-1:0]    q_s     [0:QUOT_W];
  aq_div_flags_t        flags_s [0:QUOT_W];
  logic [TAG_W-1:0]     tag_s   [0:QUOT_W];

  assign adv_s    = !OUT_VALID || OUT_READY;
  assign IN_READY = adv_s;

  // The dividend bits above the quotient seed the remainder; they are below DINB unless OVF.
  assign valid_s[0]      = IN_VALID;
  assign prem_s[0]       = PR_W'(DINA >> QUOT_W);
  assign dvd_s[0]        = QUOT_W'(DINA);
  assign dvs_s[0]        = DINB;
  assign q_s[0]          = {QUOT_W{1'b0}};
  assign flags_s[0].divz = (DINB == {DIVISOR_W{1'b0}});
  assign flags_s[0].ovf  = (DINB != {DIVISOR_W{1'b0}}) && ((DINA >> QUOT_W) >= DIVIDEND_W'(DINB));
  assign tag_s[0]        = TAG_IN;

  for (genvar g = 0; g < QUOT_W; g++) begin : g_stage
    aq_div_stage #(
      .DIVISOR_W (DIVISOR_W),
      .QUOT_W    (QUOT_W),
      .TAG_W     (TAG_W),
      .STAGE     (g)
    ) u_stage (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .adv      (adv_s),
      .up_valid (valid_s[g]),
      .up_prem  (prem_s[g]),
      .up_dvd   (dvd_s[g]),
      .up_dvs   (dvs_s[g]),
      .up_q     (q_s[g]),
      .up_flags (flags_s[g]),
      .up_tag   (tag_s[g]),
      .dn_valid (valid_s[g+1]),
      .dn_prem  (prem_s[g+1]),
      .dn_dvd   (dvd_s[g+1]),
      .dn_dvs   (dvs_s[g+1]),
      .dn_q     (q_s[g+1]),
      .dn_flags (flags_s[g+1]),
      .dn_tag   (tag_s[g+1])
    );
  end

`ifdef AQ_DIV_PIPE_REMAINDER_EN
  logic                 out_valid_r;
  logic [QUOT_W-1:0]    dout_r;
  logic                 divz_r;
  logic                 ovf_r;
  logic [TAG_W-1:0]     tag_r;
  logic [DIVISOR_W-1:0] rem_r;

  // Correction stage: restoring steps leave a non-negative remainder, so it only masks exceptions.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid_r <= 1'b0;
      dout_r      <= {QUOT_W{1'b0}};
      divz_r      <= 1'b0;
      ovf_r       <= 1'b0;
      tag_r       <= {TAG_W{1'b0}};
      rem_r       <= {DIVISOR_W{1'b0}};
    end else if (adv_s) begin
      out_valid_r <= valid_s[QUOT_W];
      dout_r      <= q_s[QUOT_W];
      divz_r      <= flags_s[QUOT_W].divz;
      ovf_r       <= flags_s[QUOT_W].ovf;
      tag_r       <= tag_s[QUOT_W];
      rem_r       <= (flags_s[QUOT_W].divz || flags_s[QUOT_W].ovf) ?
                     {DIVISOR_W{1'b0}} : DIVISOR_W'(prem_s[QUOT_W]);
    end
  end

  assign OUT_VALID = out_valid_r;
  assign DOUT      = dout_r;
  assign DIVZ      = divz_r;
  assign OVF       = ovf_r;
  assign TAG_OUT   = tag_r;
  assign REM       = rem_r;
`else
  assign OUT_VALID = valid_s[QUOT_W];
  assign DOUT      = q_s[QUOT_W];
  assign DIVZ      = flags_s[QUOT_W].divz;
  assign OVF       = flags_s[QUOT_W].ovf;
  assign TAG_OUT   = tag_s[QUOT_W];
  assign REM       = {DIVISOR_W{1'b0}};
`endif

endmodule

// File: tb/tb_aq_div_pipe.sv
// Self-checking bench for aq_div_pipe: directed table, random stream, back-pressure and reset.
module tb_aq_div_pipe;

`ifdef AQ_DIV_PIPE_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif
  localparam int LAT = REM_EN ? 9 : 8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [23:0] DINA = 24'd0;
  logic [15:0] DINB = 16'd0;
  logic [3:0]  TAG_IN = 4'd0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [7:0]  DOUT;
  logic        DIVZ;
  logic        OVF;
  logic [3:0]  TAG_OUT;
  logic [15:0] REM;

  aq_div_pipe dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .DINA(DINA), .DINB(DINB), .TAG_IN(TAG_IN), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .DOUT(DOUT), .DIVZ(DIVZ), .OVF(OVF),
    .TAG_OUT(TAG_OUT), .REM(REM)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  dout;
    logic        divz;
    logic        ovf;
    logic [3:0]  tag;
    logic [15:0] rem;
  } exp_t;

  typedef struct {
    logic [23:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    exp_t        e;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   n_out = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: straight integer division and the flag rules.
  function automatic exp_t model(input logic [23:0] a, input logic [15:0] b, input logic [3:0] tag);
    exp_t   r;
    longint q;
    r.tag = tag; r.divz = 1'b0; r.ovf = 1'b0; r.rem = 16'd0;
    if (b == 16'd0) begin
      r.dout = 8'hFF; r.divz = 1'b1;
    end else begin
      q = longint'(a) / longint'(b);
      if (q >= 256) begin
        r.dout = 8'hFF; r.ovf = 1'b1;
      end else begin
        r.dout = 8'(q);
        if (REM_EN) r.rem = 16'(longint'(a) - q * longint'(b));
      end
    end
    return r;
  endfunction

  // One clock: score an output take, record an input accept, then move to the next falling edge.
  task automatic tick(input exp_t e, output bit fired);
    exp_t x;
    #1;
    if (OUT_VALID && OUT_READY) begin
      chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        n_out++;
        chk("dout", 32'(DOUT), 32'(x.dout));
        chk("tag", 32'(TAG_OUT), 32'(x.tag));
        chk("divz", 32'(DIVZ), 32'(x.divz));
        chk("ovf", 32'(OVF), 32'(x.ovf));
        chk("rem", 32'(REM), 32'(x.rem));
      end
    end
    fired = IN_VALID && IN_READY;
    if (fired) exp_q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic drain();
    exp_t d;
    bit   f;
    int   n;
    IN_VALID = 1'b0;
    n = 0;
    d = model(24'd0, 16'd1, 4'd0);
    while (exp_q.size() != 0 && n < 60) begin
      tick(d, f);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    vec_t        vt[10];
    exp_t        e;
    bit          f;
    int          n;
    int          stale;
    int          base;
    logic [7:0]  held_dout;
    logic [3:0]  held_tag;
    logic [23:0] a;
    logic [15:0] b;
    logic [3:0]  t;

    vt[0] = '{24'd1000,     16'd10,    4'd3,  '{8'd100, 1'b0, 1'b0, 4'd3,  16'd0}};
    vt[1] = '{24'hFFFFFF,   16'd1,     4'd5,  '{8'hFF,  1'b0, 1'b1, 4'd5,  16'd0}};
    vt[2] = '{24'h0000FF,   16'd1,     4'd6,  '{8'hFF,  1'b0, 1'b0, 4'd6,  16'd0}};
    vt[3] = '{24'd1003,     16'd10,    4'd7,  '{8'd100, 1'b0, 1'b0, 4'd7,  16'd3}};
    vt[4] = '{24'd12345,    16'd0,     4'd8,  '{8'hFF,  1'b1, 1'b0, 4'd8,  16'd0}};
    vt[5] = '{24'd1792,     16'd7,     4'd9,  '{8'hFF,  1'b0, 1'b1, 4'd9,  16'd0}};
    vt[6] = '{24'd1791,     16'd7,     4'd10, '{8'd255, 1'b0, 1'b0, 4'd10, 16'd6}};
    vt[7] = '{24'd0,        16'd5,     4'd11, '{8'd0,   1'b0, 1'b0, 4'd11, 16'd0}};
    vt[8] = '{24'hFFFFFF,   16'hFFFF,  4'd12, '{8'hFF,  1'b0, 1'b1, 4'd12, 16'd0}};
    vt[9] = '{24'd16776959, 16'hFFFF,  4'd13, '{8'd255, 1'b0, 1'b0, 4'd13, 16'd65534}};

    // Reset state.
    repeat (3) @(negedge CLK);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_dout", 32'(DOUT), 32'd0);
    chk("rst_flags", 32'({DIVZ, OVF}), 32'd0);
    chk("rst_tag", 32'(TAG_OUT), 32'd0);
    chk("rst_rem", 32'(REM), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Single operation latency: 1000/10, tag 3.
    DINA = 24'd1000; DINB = 16'd10; TAG_IN = 4'd3; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    n = 1;
    while (!OUT_VALID && n < 30) begin
      @(negedge CLK);
      n++;
    end
    chk("latency", 32'(n), 32'(LAT));
    chk("lat_dout", 32'(DOUT), 32'd100);
    chk("lat_tag", 32'(TAG_OUT), 32'd3);
    chk("lat_flags", 32'({DIVZ, OVF}), 32'd0);
    chk("lat_rem", 32'(REM), 32'd0);
    @(negedge CLK);
    chk("valid_drop", 32'(OUT_VALID), 32'd0);

    // Directed table, issued back to back.
    for (int i = 0; i < 10; i++) begin
      DINA = vt[i].a; DINB = vt[i].b; TAG_IN = vt[i].tag; IN_VALID = 1'b1;
      e = vt[i].e;
      if (!REM_EN) e.rem = 16'd0;
      tick(e, f);
      chk("table_accept", 32'(f), 32'd1);
    end
    drain();

    // 20 random back-to-back operations with wrapping tags.
    base = n_out;
    for (int i = 0; i < 20; i++) begin
      b = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) b = 16'd0;
      a = 24'($urandom);
      if ($urandom_range(0, 1) == 1) a = 24'($urandom_range(0, 255) * b + $urandom_range(0, 30));
      t = 4'(i);
      DINA = a; DINB = b; TAG_IN = t; IN_VALID = 1'b1;
      tick(model(a, b, t), f);
    end
    drain();
    chk("random_count", 32'(n_out - base), 32'd20);

    // Back-pressure with a full pipe.
    base = n_out;
    n = 0;
    a = 24'($urandom); b = 16'($urandom_range(1, 65535)); t = 4'd0;
    for (int i = 0; i < LAT + 3; i++) begin
      DINA = a; DINB = b; TAG_IN = t; IN_VALID = 1'b1;
      tick(model(a, b, t), f);
      if (f) begin
        n++; t = t + 4'd1;
        a = 24'($urandom); b = 16'($urandom_range(1, 65535));
      end
    end
    OUT_READY = 1'b0;
    #1;
    held_dout = DOUT;
    held_tag = TAG_OUT;
    chk("bp_out_valid", 32'(OUT_VALID), 32'd1);
    for (int i = 0; i < 5; i++) begin
      DINA = a; DINB = b; TAG_IN = t;
      tick(model(a, b, t), f);
      chk("bp_in_ready", 32'(IN_READY), 32'd0);
      chk("bp_dout_stable", 32'(DOUT), 32'(held_dout));
      chk("bp_tag_stable", 32'(TAG_OUT), 32'(held_tag));
    end
    OUT_READY = 1'b1;
    #1;
    chk("bp_ready_rise", 32'(IN_READY), 32'd1);
    for (int i = 0; i < 6; i++) begin
      DINA = a; DINB = b; TAG_IN = t; IN_VALID = 1'b1;
      tick(model(a, b, t), f);
      if (f) begin
        n++; t = t + 4'd1;
        a = 24'($urandom); b = 16'($urandom_range(1, 65535));
      end
    end
    drain();
    chk("bp_count", 32'(n_out - base), 32'(n));

    // Reset with operations in flight.
    for (int i = 0; i < 4; i++) begin
      DINA = 24'(100 + i); DINB = 16'd3; TAG_IN = 4'(i); IN_VALID = 1'b1;
      tick(model(24'(100 + i), 16'd3, 4'(i)), f);
    end
    IN_VALID = 1'b0;
    n = 0;
    while (!OUT_VALID && n < 30) begin
      @(negedge CLK);
      n++;
    end
    chk("inflight_visible", 32'(OUT_VALID), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_valid", 32'(OUT_VALID), 32'd0);
    chk("async_rst_dout", 32'(DOUT), 32'd0);
    exp_q.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    stale = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge CLK);
      if (OUT_VALID) stale++;
    end
    chk("no_stale", 32'(stale), 32'd0);
    base = n_out;
    DINA = 24'd50; DINB = 16'd7; TAG_IN = 4'd9; IN_VALID = 1'b1;
    e = '{8'd7, 1'b0, 1'b0, 4'd9, REM_EN ? 16'd1 : 16'd0};
    tick(e, f);
    drain();
    chk("post_rst_count", 32'(n_out - base), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aq_div_pipe.md
Name: aq_div_pipe

Overview:
Parametrised, fully pipelined unsigned integer divider with a valid/ready handshake. It is the general successor of the fixed 24/16→8 pipelined divider. It accepts one division per cycle and returns one quotient bit per pipeline stage. It also provides divide-by-zero and overflow flags, a sideband tag, and back-pressure. It sits in the AXIS reduce datapath (averaging, normalisation) between the accumulate stage and output formatting.

Parameters:
DIVIDEND_W, 24, dividend width (≥2)
DIVISOR_W, 16, divisor width (≥1, ≤DIVIDEND_W)
QUOT_W, 8, quotient width = pipeline depth in stages (1..DIVIDEND_W)
TAG_W, 4, sideband tag width carried alongside each operation (≥1)

Ports:
CLK  in  1  clock, all flops rising edge
RST_N  in  1  reset, asynchronous, active-low
IN_VALID  in  1  operand valid
IN_READY  out  1  block accepts operands this cycle
DINA  in  DIVIDEND_W  dividend, unsigned
DINB  in  DIVISOR_W  divisor, unsigned
TAG_IN  in  TAG_W  sideband, passed through unchanged
OUT_VALID  out  1  result valid
OUT_READY  in  1  downstream accepts result
DOUT  out  QUOT_W  quotient
DIVZ  out  1  divisor was zero
OVF  out  1  true quotient ≥ 2^QUOT_W
TAG_OUT  out  TAG_W  tag of the operation on DOUT
REM  out  DIVISOR_W  remainder (only with feature; tied 0 without)

Behaviour:
- Reset (async assert, sync-safe deassert via CLK): all stage valid bits 0; OUT_VALID=0, DOUT=0, DIVZ=0, OVF=0, TAG_OUT=0, REM=0. All datapath regs are cleared.
- Result definition:
  - If DINB==0: DOUT = all-ones, DIVZ=1, OVF=0.
  - Else if floor(DINA/DINB) ≥ 2^QUOT_W: DOUT = all-ones, OVF=1.
  - Else: DOUT = floor(DINA/DINB), both flags 0.
- Arithmetic:
  - Restoring or non-restoring shift-subtract, one quotient bit per stage, MSB first.
  - Partial remainder width is DIVISOR_W+1.
  - The divisor, flags and tag ride down the pipeline with the data.
- Overflow detect at stage 0: OVF when DINB≠0 and DINA[DIVIDEND_W-1:QUOT_W] ≥ DINB (zero-extended compare). When QUOT_W==DIVIDEND_W, OVF is constant 0.
- Pipeline: QUOT_W register stages, each holding a valid bit.
  - Global advance: adv = !OUT_VALID | OUT_READY.
  - IN_READY = adv (combinational from OUT_VALID/OUT_READY only, never from IN_VALID).
  - Transfer in when IN_VALID & IN_READY.
  - When adv=0, every stage holds, including valid bits and data.
  - Bubbles are not collapsed.
- Latency: exactly QUOT_W advancing cycles from input transfer to OUT_VALID. Throughput is 1 per cycle when OUT_READY is held high.
- Output held stable while OUT_VALID & !OUT_READY (AXIS rule). OUT_VALID drops the cycle after the last result is taken if no new data follows.
- Ordering: strictly in order; TAG_OUT always pairs with its own DOUT.
- Simultaneous input accept and output take in the same cycle: both occur, with no loss or duplication.
- Reset mid-operation: every in-flight operation is discarded; no partial result ever appears after reset.

Optional Feature:
- Macro AQ_DIV_PIPE_REMAINDER_EN.
- Defined:
  - Adds one final correction stage, so latency = QUOT_W+1.
  - REM = DINA - DOUT*DINB, valid only when DIVZ=0 and OVF=0. Otherwise REM=0.
  - For non-restoring implementations, the correction stage adds DINB back when the partial remainder is negative.
- Undefined: no extra stage, REM tied to 0, latency = QUOT_W.

Decomposition:
- Package aq_div_pkg holds:
  - localparam function for partial-remainder width (DIVISOR_W+1)
  - stage-payload struct typedef: partial remainder, shifted dividend, divisor, quotient bits, divz, ovf, tag
- Sub-module aq_div_stage: one shift-subtract step plus valid/hold register, parametrised by stage index. The top module generates QUOT_W instances in a generate loop.

Test Plan:
- Defaults; DINA=1000, DINB=10, TAG_IN=3, OUT_READY=1 → after 8 cycles OUT_VALID=1, DOUT=100, TAG_OUT=3, DIVZ=0, OVF=0; with feature: 9 cycles, REM=0.
- DINA=0xFFFFFF, DINB=1 → DOUT=0xFF, OVF=1. DINA=0x0000FF, DINB=1 → DOUT=0xFF, OVF=0. DINA=1003, DINB=10 with feature → DOUT=100, REM=3.
- DINB=0, DINA=12345 → DOUT=0xFF, DIVZ=1, OVF=0.
- 20 back-to-back random operands, OUT_READY=1 → 20 consecutive results, in order, matching a reference model, with tags 0..15 wrapping correctly.
- OUT_READY=0 for 5 cycles while the pipe is full → IN_READY=0, DOUT/TAG_OUT stable. Then release → no loss or duplication, and IN_READY rises in the same cycle as OUT_READY.
- Assert RST_N=0 for one cycle with 4 ops in flight → OUT_VALID=0 immediately (async). No stale results after release; the next op 50/7 → DOUT=7.
